mure_block_scheduler: RTL and testbench
=======================================

Name: mure_block_scheduler

Overview:
- Sits between the multi-retirement block builder and a single-port trace encoder.
- Accepts up to N instruction-trace blocks per cycle as one group and buffers groups in order.
- Emits exactly one block per cycle on a valid/ready handshake.
- Gives upstream backpressure (ready_o) and records overflow when a group is dropped.

Parameters:
- N, 2: max blocks per input group (N >= 1).
- GROUP_DEPTH, 8: number of buffered groups (power of 2, >= 2).
- DROP_CNT_LEN, 16: width of the saturating drop counter.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- valid_i  in  N  per-slot block valid; any set bit makes the group valid.
- iretire_i  in  N x mure_pkg::IRETIRE_LEN  retired-unit count per block.
- ilastsize_i  in  N  last-instruction size per block.
- itype_i  in  N x mure_pkg::ITYPE_LEN  block type.
- iaddr_i  in  N x mure_pkg::XLEN  block address.
- cause_i  in  mure_pkg::CAUSE_LEN  exception/interrupt cause for the group.
- tval_i  in  mure_pkg::XLEN  trap value for the group.
- priv_i  in  mure_pkg::PRIV_LEN  privilege level for the group.
- ready_o  out  1  group can be accepted this cycle.
- valid_o  out  1  output block valid.
- ready_i  in  1  encoder accepts the output block.
- iretire_o, ilastsize_o, itype_o, iaddr_o  out  per-block widths  current block fields.
- cause_o, tval_o, priv_o  out  as inputs  group fields for the current block.
- overflow_o  out  1  sticky: a group was dropped.
- drop_cnt_o  out  DROP_CNT_LEN  saturating count of dropped groups.

Behaviour:
- Reset (async, rst_ni=0):
  - All outputs 0, except ready_o=1.
  - FIFO empty, FSM IDLE, idx=0.
  - Overflow flag and drop counter cleared.
  - Reset mid-emission discards all buffered groups; no partial group is emitted after reset.
- ready_o:
  - ready_o = !fifo_full, registered-state based.
  - No same-cycle pass-through: a pop in the same cycle does not free a slot for a push.
- Accept:
  - Push when |valid_i && ready_o.
  - Set bits of valid_i are compacted in ascending index order into slots 0..count-1.
  - count = popcount(valid_i), range 1..N, stored with the group.
  - cause/tval/priv are stored once per group.
- Drop:
  - Triggered when |valid_i && !ready_o.
  - The group is discarded and overflow_o is set (sticky until reset).
  - drop_cnt_o increments and saturates at all-ones.
  - valid_i=0 is never pushed and never counts as a drop.
- Latency: a group pushed in cycle t can first appear on valid_o in cycle t+1.
- FSM:
  - IDLE: valid_o=0; if fifo not empty -> EMIT with idx=0.
  - EMIT: valid_o=1; fields come from head group slot idx.
    - On valid_o&&ready_i with idx<count-1: idx++.
    - On valid_o&&ready_i with idx==count-1: pop head, idx=0; stay EMIT if another group remains after the pop, else IDLE.
    - If !ready_i: hold all outputs stable (AXI-style; valid never drops without a handshake).
- cause_o/tval_o:
  - Driven from the group only when itype_o is 1 (exception) or 2 (interrupt); otherwise 0.
  - priv_o is always the group value while valid_o=1, else 0.
- Ordering: strict FIFO across groups, ascending slot order within a group.
- Throughput: back-to-back groups emit with no idle bubble (one block per cycle with ready_i held high).
- Simultaneous push and final pop: both take effect; the new group follows immediately.
- FIFO pointers: log2(GROUP_DEPTH) bits plus a wrap bit for full/empty. Wrap-around needs no special handling.

Decomposition:
- mure_pkg:
  - Add typedef block_s {iretire, ilastsize, itype, iaddr}.
  - Add typedef block_group_s {block_s [N-1:0] blk; count; cause; tval; priv}. Slot width is set by a package constant, MAX_BLOCKS, aligned with N.
  - Reuse the existing ITYPE_EXC=1 / ITYPE_INT=2 constants.
- Sub-module: the group buffer reuses the existing fifo_v3 (dtype block_group_s).
- The compaction logic is a natural small sub-module, block_compactor (combinational popcount plus prefix index).

Test Plan:
1. Single-block group: valid_i=2'b01, itype=4, iaddr=0x80000000, ready_i=1 → valid_o in the next cycle for 1 cycle with iaddr_o=0x80000000, cause_o=0, tval_o=0.
2. Sparse group: valid_i=2'b10, iaddr_i[1]=0x100 → one block emitted with iaddr_o=0x100.
3. Dual group with backpressure:
   - Stimulus: valid_i=2'b11 with iaddr 0x10 and 0x20; ready_i=0 for 3 cycles, then 1.
   - Required: 0x10 held stable for 3 cycles, then 0x10 and 0x20 on consecutive cycles.
4. Exception block: itype_i[0]=1, cause_i=2, tval_i=0xDEAD → cause_o=2, tval_o=0xDEAD while that block is valid; a following itype=4 block shows cause_o=0.
5. Overflow:
   - Stimulus: ready_i=0; push GROUP_DEPTH+3 groups.
   - Required: ready_o=0 after GROUP_DEPTH pushes, overflow_o=1, drop_cnt_o=3.
   - After release, exactly GROUP_DEPTH groups drain in order.
6. Reset mid-emission: assert rst_ni=0 while a 2-block group is half emitted → valid_o=0 and ready_o=1 immediately; after deassert no stale block appears.

Source files
------------

// File: rtl/mure_pkg.sv
// mure_pkg: shared trace widths, itype codes and the buffered block/group records.
package mure_pkg;
  localparam int XLEN        = 32;
  localparam int IRETIRE_LEN = 3;
  localparam int ITYPE_LEN   = 3;
  localparam int CAUSE_LEN   = 5;
  localparam int PRIV_LEN    = 2;
  localparam int MAX_BLOCKS  = 2;
  localparam int CNT_W       = $clog2(MAX_BLOCKS + 1);
  localparam int IDX_W       = (MAX_BLOCKS > 1) ? $clog2(MAX_BLOCKS) : 1;
  localparam logic [ITYPE_LEN-1:0] ITYPE_EXC = 3'd1;
  localparam logic [ITYPE_LEN-1:0] ITYPE_INT = 3'd2;
  typedef struct packed {
    logic [IRETIRE_LEN-1:0] iretire;
    logic                   ilastsize;
    logic [ITYPE_LEN-1:0]   itype;
    logic [XLEN-1:0]        iaddr;
  } block_s;
  typedef struct packed {
    block_s [MAX_BLOCKS-1:0] blk;
    logic [CNT_W-1:0]        count;
    logic [CAUSE_LEN-1:0]    cause;
    logic [XLEN-1:0]         tval;
    logic [PRIV_LEN-1:0]     priv;
  } block_group_s;
  function automatic logic is_trap(input logic [ITYPE_LEN-1:0] t);
    return t == ITYPE_EXC || t == ITYPE_INT;
  endfunction
endpackage

// File: rtl/block_compactor.sv
// block_compactor: packs the valid slots of a group into slots 0..count-1 in ascending order.
module block_compactor
  import mure_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]                     valid_i,
  input  block_s [N-1:0]                   blk_i,
  output block_s [MAX_BLOCKS-1:0]          blk_o,
  output logic [CNT_W-1:0]                 count_o
);
  always_comb begin
    blk_o   = '0;
    count_o = '0;
    for (int i = 0; i < N; i++) begin
      if (valid_i[i]) begin
        blk_o[count_o[IDX_W-1:0]] = blk_i[i];
        count_o = count_o + CNT_W'(1);
      end
    end
  end
endmodule

// File: rtl/fifo_v3.sv
// fifo_v3: generic first-word-fall-through FIFO with wrap-bit pointers and occupancy.
module fifo_v3 #(
  parameter int DEPTH = 8,
  parameter type dtype = logic,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        push_i,
  input  dtype        data_i,
  input  logic        pop_i,
  output dtype        data_o,
  output logic        full_o,
  output logic        empty_o,
  output logic [AW:0] usage_o
);
  localparam logic [AW:0] ONE = (AW+1)'(1);
  dtype mem_q [DEPTH];
  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  assign usage_o = wptr_q - rptr_q;
  assign empty_o = wptr_q == rptr_q;
  assign full_o  = usage_o == (AW+1)'(DEPTH);
  assign data_o  = mem_q[rptr_q[AW-1:0]];
  assign wptr_d  = (push_i && !full_o) ? wptr_q + ONE : wptr_q;
  assign rptr_d  = (pop_i && !empty_o) ? rptr_q + ONE : rptr_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (push_i && !full_o) mem_q[wptr_q[AW-1:0]] <= data_i;
  end
endmodule

// File: rtl/mure_block_scheduler.sv
// mure_block_scheduler: buffers multi-block retirement groups and serialises them,
// one block per valid/ready handshake, to a single-port trace encoder.
module mure_block_scheduler
  import mure_pkg::*;
#(
  parameter int N            = 2,
  parameter int GROUP_DEPTH  = 8,
  parameter int DROP_CNT_LEN = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [N-1:0]                  valid_i,
  input  logic [N-1:0][IRETIRE_LEN-1:0] iretire_i,
  input  logic [N-1:0]                  ilastsize_i,
  input  logic [N-1:0][ITYPE_LEN-1:0]   itype_i,
  input  logic [N-1:0][XLEN-1:0]        iaddr_i,
  input  logic [CAUSE_LEN-1:0]          cause_i,
  input  logic [XLEN-1:0]               tval_i,
  input  logic [PRIV_LEN-1:0]           priv_i,
  output logic                          ready_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [IRETIRE_LEN-1:0]        iretire_o,
  output logic                          ilastsize_o,
  output logic [ITYPE_LEN-1:0]          itype_o,
  output logic [XLEN-1:0]               iaddr_o,
  output logic [CAUSE_LEN-1:0]          cause_o,
  output logic [XLEN-1:0]               tval_o,
  output logic [PRIV_LEN-1:0]           priv_o,
  output logic                          overflow_o,
  output logic [DROP_CNT_LEN-1:0]       drop_cnt_o
);
  localparam int AW = $clog2(GROUP_DEPTH);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;
  block_s [N-1:0]          in_blk;
  block_s [MAX_BLOCKS-1:0] packed_blk;
  logic [CNT_W-1:0]        packed_cnt;
  block_group_s            wr_grp, head;
  block_s                  cur;
  logic                    full, empty, push, pop, last, any_valid, drop;
  logic [AW:0]             usage;
  logic [0:0]              state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    overflow_q, overflow_d;
  logic [DROP_CNT_LEN-1:0] drop_cnt_q, drop_cnt_d;
  for (genvar i = 0; i < N; i++) begin : g_in
    assign in_blk[i] = '{iretire: iretire_i[i], ilastsize: ilastsize_i[i], itype: itype_i[i], iaddr: iaddr_i[i]};
  end
  block_compactor #(.N(N)) u_compactor (
    .valid_i (valid_i),
    .blk_i   (in_blk),
    .blk_o   (packed_blk),
    .count_o (packed_cnt)
  );
  assign wr_grp = '{blk: packed_blk, count: packed_cnt, cause: cause_i, tval: tval_i, priv: priv_i};
  fifo_v3 #(.DEPTH(GROUP_DEPTH), .dtype(block_group_s)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (wr_grp),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .usage_o (usage)
  );
  // ready depends only on stored occupancy, so a pop never frees a slot for a same-cycle push
  assign any_valid = |valid_i;
  assign ready_o   = !full;
  assign push      = any_valid && !full;
  assign drop      = any_valid && full;
  assign valid_o   = state_q == EMIT;
  assign cur       = head.blk[idx_q];
  assign last      = CNT_W'(idx_q) == head.count - CNT_W'(1);
  assign pop       = valid_o && ready_i && last;
  assign state_d   = valid_o ? ((pop && usage == (AW+1)'(1) && !push) ? IDLE : EMIT)
                             : ((push || !empty) ? EMIT : IDLE);
  assign idx_d     = (valid_o && ready_i) ? (last ? '0 : idx_q + IDX_W'(1)) : idx_q;
  assign overflow_d = overflow_q || drop;
  assign drop_cnt_d = (drop && !(&drop_cnt_q)) ? drop_cnt_q + DROP_CNT_LEN'(1) : drop_cnt_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end
  assign iretire_o   = valid_o ? cur.iretire : '0;
  assign ilastsize_o = valid_o ? cur.ilastsize : 1'b0;
  assign itype_o     = valid_o ? cur.itype : '0;
  assign iaddr_o     = valid_o ? cur.iaddr : '0;
  assign cause_o     = (valid_o && is_trap(cur.itype)) ? head.cause : '0;
  assign tval_o      = (valid_o && is_trap(cur.itype)) ? head.tval : '0;
  assign priv_o      = valid_o ? head.priv : '0;
  assign overflow_o  = overflow_q;
  assign drop_cnt_o  = drop_cnt_q;
endmodule

// File: tb/tb_mure_block_scheduler.sv
// tb_mure_block_scheduler: directed tests checked against a block-queue model every cycle.
module tb_mure_block_scheduler;
  import mure_pkg::*;
  localparam int N = 2;
  localparam int D = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [N-1:0]                  valid_i = '0;
  logic [N-1:0][IRETIRE_LEN-1:0] iretire_i = '0;
  logic [N-1:0]                  ilastsize_i = '0;
  logic [N-1:0][ITYPE_LEN-1:0]   itype_i = '0;
  logic [N-1:0][XLEN-1:0]        iaddr_i = '0;
  logic [CAUSE_LEN-1:0]          cause_i = '0;
  logic [XLEN-1:0]               tval_i = '0;
  logic [PRIV_LEN-1:0]           priv_i = '0;
  logic                          ready_i = 1'b0;
  logic                          ready_o, valid_o, ilastsize_o, overflow_o;
  logic [IRETIRE_LEN-1:0]        iretire_o;
  logic [ITYPE_LEN-1:0]          itype_o;
  logic [XLEN-1:0]               iaddr_o, tval_o;
  logic [CAUSE_LEN-1:0]          cause_o;
  logic [PRIV_LEN-1:0]           priv_o;
  logic [15:0]                   drop_cnt_o;

  mure_block_scheduler #(.N(N), .GROUP_DEPTH(D), .DROP_CNT_LEN(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .iretire_i(iretire_i),
    .ilastsize_i(ilastsize_i), .itype_i(itype_i), .iaddr_i(iaddr_i), .cause_i(cause_i),
    .tval_i(tval_i), .priv_i(priv_i), .ready_o(ready_o), .valid_o(valid_o), .ready_i(ready_i),
    .iretire_o(iretire_o), .ilastsize_o(ilastsize_o), .itype_o(itype_o), .iaddr_o(iaddr_o),
    .cause_o(cause_o), .tval_o(tval_o), .priv_o(priv_o), .overflow_o(overflow_o),
    .drop_cnt_o(drop_cnt_o)
  );

  int vectors = 0;
  int miscompares = 0;
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // model: flat queue of pending blocks in emission order, plus a count of buffered groups
  typedef struct {
    logic [IRETIRE_LEN-1:0] ir;
    logic                   ls;
    logic [ITYPE_LEN-1:0]   ty;
    logic [XLEN-1:0]        ad;
    logic [CAUSE_LEN-1:0]   ca;
    logic [XLEN-1:0]        tv;
    logic [PRIV_LEN-1:0]    pr;
    bit                     last;
  } mblk_t;
  mblk_t mq[$];
  int    mgroups = 0;
  bit    movf = 0;
  int    mdrop = 0;

  always @(posedge clk or negedge rst_n) begin : model
    mblk_t b;
    bit was_full;
    int n, k;
    if (!rst_n) begin
      mq.delete();
      mgroups = 0;
      movf = 0;
      mdrop = 0;
    end else begin
      was_full = mgroups >= D;
      if (mq.size() != 0 && ready_i) begin
        if (mq[0].last) mgroups--;
        void'(mq.pop_front());
      end
      if (|valid_i) begin
        if (was_full) begin
          movf = 1;
          if (mdrop < 65535) mdrop++;
        end else begin
          n = $countones(valid_i);
          k = 0;
          for (int i = 0; i < N; i++) begin
            if (valid_i[i]) begin
              k++;
              b.ir = iretire_i[i];
              b.ls = ilastsize_i[i];
              b.ty = itype_i[i];
              b.ad = iaddr_i[i];
              b.ca = (b.ty == 3'd1 || b.ty == 3'd2) ? cause_i : '0;
              b.tv = (b.ty == 3'd1 || b.ty == 3'd2) ? tval_i : '0;
              b.pr = priv_i;
              b.last = (k == n);
              mq.push_back(b);
            end
          end
          mgroups++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("m_ready", 64'(ready_o), 64'(mgroups < D));
      check("m_valid", 64'(valid_o), 64'(mq.size() != 0));
      if (mq.size() != 0) begin
        check("m_iaddr", 64'(iaddr_o), 64'(mq[0].ad));
        check("m_itype", 64'(itype_o), 64'(mq[0].ty));
        check("m_iretire", 64'(iretire_o), 64'(mq[0].ir));
        check("m_ilastsize", 64'(ilastsize_o), 64'(mq[0].ls));
        check("m_cause", 64'(cause_o), 64'(mq[0].ca));
        check("m_tval", 64'(tval_o), 64'(mq[0].tv));
        check("m_priv", 64'(priv_o), 64'(mq[0].pr));
      end else begin
        check("m_priv_idle", 64'(priv_o), 64'(0));
        check("m_cause_idle", 64'(cause_o), 64'(0));
      end
      check("m_overflow", 64'(overflow_o), 64'(movf));
      check("m_drop_cnt", 64'(drop_cnt_o), 64'(mdrop));
    end
  end

  task automatic send(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] a1,
                      input logic [2:0] t0, input logic [2:0] t1, input logic [4:0] c,
                      input logic [31:0] tv, input logic [1:0] p);
    valid_i = v;
    iaddr_i[0] = a0;
    iaddr_i[1] = a1;
    itype_i[0] = t0;
    itype_i[1] = t1;
    iretire_i[0] = a0[2:0] ^ 3'd5;
    iretire_i[1] = a1[2:0] ^ 3'd6;
    ilastsize_i[0] = a0[4];
    ilastsize_i[1] = a1[4];
    cause_i = c;
    tval_i = tv;
    priv_i = p;
    @(posedge clk);
    #1;
    valid_i = '0;
  endtask

  initial begin
    #12;
    check("rst_ready", 64'(ready_o), 64'(1));
    check("rst_valid", 64'(valid_o), 64'(0));
    check("rst_overflow", 64'(overflow_o), 64'(0));
    check("rst_drop", 64'(drop_cnt_o), 64'(0));
    check("rst_iaddr", 64'(iaddr_o), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    // single block; trap fields suppressed for itype 4
    ready_i = 1'b1;
    send(2'b01, 32'h8000_0000, 32'h0, 3'd4, 3'd0, 5'd3, 32'h55, 2'd3);
    @(negedge clk);
    check("t1_valid", 64'(valid_o), 64'(1));
    check("t1_iaddr", 64'(iaddr_o), 64'h8000_0000);
    check("t1_cause", 64'(cause_o), 64'(0));
    check("t1_tval", 64'(tval_o), 64'(0));
    check("t1_priv", 64'(priv_o), 64'(3));
    @(negedge clk);
    check("t1_gone", 64'(valid_o), 64'(0));
    // sparse group compacts slot 1 into slot 0
    send(2'b10, 32'h999, 32'h100, 3'd0, 3'd4, 5'd0, 32'h0, 2'd1);
    @(negedge clk);
    check("t2_iaddr", 64'(iaddr_o), 64'h100);
    @(negedge clk);
    check("t2_gone", 64'(valid_o), 64'(0));
    // dual group under backpressure
    ready_i = 1'b0;
    send(2'b11, 32'h10, 32'h20, 3'd4, 3'd4, 5'd0, 32'h0, 2'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t3_hold", 64'(iaddr_o), 64'h10);
    end
    ready_i = 1'b1;
    @(negedge clk);
    check("t3_second", 64'(iaddr_o), 64'h20);
    @(negedge clk);
    check("t3_gone", 64'(valid_o), 64'(0));
    // exception block then plain block in the same group
    send(2'b11, 32'h40, 32'h44, 3'd1, 3'd4, 5'd2, 32'hDEAD, 2'd1);
    @(negedge clk);
    check("t4_cause", 64'(cause_o), 64'(2));
    check("t4_tval", 64'(tval_o), 64'hDEAD);
    @(negedge clk);
    check("t4_iaddr2", 64'(iaddr_o), 64'h44);
    check("t4_cause2", 64'(cause_o), 64'(0));
    @(negedge clk);
    // back-to-back groups, interrupt type, push coinciding with final pop
    send(2'b11, 32'h50, 32'h54, 3'd2, 3'd4, 5'd7, 32'hBEEF, 2'd0);
    send(2'b01, 32'h60, 32'h0, 3'd4, 3'd0, 5'd1, 32'h1, 2'd2);
    send(2'b10, 32'h0, 32'h70, 3'd0, 3'd1, 5'd9, 32'h77, 2'd3);
    repeat (4) @(negedge clk);
    check("bb_drained", 64'(valid_o), 64'(0));
    // overflow: D+3 groups against a stalled encoder
    ready_i = 1'b0;
    for (int k = 0; k < D + 3; k++) begin
      send(2'b01, 32'h1000 + 32'(k), 32'h0, 3'd4, 3'd0, 5'd0, 32'h0, 2'd0);
      if (k == D - 2) check("t5_not_full", 64'(ready_o), 64'(1));
      if (k == D - 1) check("t5_full", 64'(ready_o), 64'(0));
    end
    @(negedge clk);
    check("t5_overflow", 64'(overflow_o), 64'(1));
    check("t5_drop", 64'(drop_cnt_o), 64'(3));
    check("t5_head", 64'(iaddr_o), 64'h1000);
    ready_i = 1'b1;
    for (int j = 1; j < D; j++) begin
      @(negedge clk);
      check("t5_order", 64'(iaddr_o), 64'h1000 + 64'(j));
    end
    @(negedge clk);
    check("t5_empty", 64'(valid_o), 64'(0));
    check("t5_sticky", 64'(overflow_o), 64'(1));
    // reset while a 2-block group is half emitted
    send(2'b11, 32'h200, 32'h204, 3'd4, 3'd4, 5'd0, 32'h0, 2'd1);
    @(negedge clk);
    check("t6_first", 64'(iaddr_o), 64'h200);
    @(posedge clk);
    #2;
    check("t6_half", 64'(iaddr_o), 64'h204);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 64'(valid_o), 64'(0));
    check("t6_rst_ready", 64'(ready_o), 64'(1));
    check("t6_rst_overflow", 64'(overflow_o), 64'(0));
    check("t6_rst_drop", 64'(drop_cnt_o), 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("t6_no_stale", 64'(valid_o), 64'(0));
    end
    send(2'b01, 32'h300, 32'h0, 3'd4, 3'd0, 5'd0, 32'h0, 2'd2);
    @(negedge clk);
    check("t6_after", 64'(iaddr_o), 64'h300);
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
